// File: rtl/apb4_master_if.sv
// rtl/apb4_master_if.sv - command/response and APB4 signal bundle for apb4_master
interface apb4_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Command channel
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [DATA_WIDTH/8-1:0] cmd_strb;
    logic [2:0]              cmd_prot;

    // Response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    // APB4 bus
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [2:0]              PPROT;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    // Bridge side: takes commands, returns responses, drives the APB requester pins
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    // Environment side: command issuer, response consumer and APB completer
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_master.sv
// rtl/apb4_master.sv - single-outstanding command to APB4 requester bridge with access timeout
module apb4_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    apb4_master_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value seen on the last PREADY-low cycle before the abort fires
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_W-1:0]       pstrb_q;
    logic [2:0]              pprot_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    timeout_hit;

    assign cnt_d       = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Transfer sequencer: all bus and response outputs are registered here
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_ready_q && bus.cmd_valid) begin
                        state_q     <= SETUP;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        pwrite_q    <= bus.cmd_write;
                        paddr_q     <= bus.cmd_addr;
                        pprot_q     <= bus.cmd_prot;
                        cnt_q       <= '0;
                        // Reads leave PWDATA untouched and present no strobes
                        if (bus.cmd_write) begin
                            pwdata_q <= bus.cmd_wdata;
                            pstrb_q  <= bus.cmd_strb;
                        end else begin
                            pstrb_q  <= '0;
                        end
                    end else begin
                        // Covers the first edge after reset release
                        cmd_ready_q <= 1'b1;
                    end
                end

                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end

                ACCESS: begin
                    if (bus.PREADY) begin
                        // Completer response wins even on the timeout cycle
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                        rsp_err_q     <= bus.PSLVERR;
                        rsp_timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;
    assign bus.PPROT       = pprot_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb4_master.sv
// tb/tb_apb4_master.sv - self-checking bench for apb4_master
module tb_apb4_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    apb4_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb4_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    // Last value written onto PWDATA; reads must leave it untouched
    logic [DW-1:0] model_pw = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_cmd();
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = SW'($urandom);
        bus.cmd_prot  = 3'($urandom);
    endtask

    task automatic junk_apb(input bit rdy);
        bus.PREADY  = rdy;
        bus.PSLVERR = 1'($urandom);
        bus.PRDATA  = $urandom;
    endtask

    // One complete transfer; expectations are derived from the transaction alone
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] st, input logic [2:0] pr, input int waits,
                        input bit serr, input logic [DW-1:0] rd, input int hold, input bit pend);
        logic [DW-1:0] exp_pw;
        logic [SW-1:0] exp_st;
        logic [DW-1:0] exp_rd;
        bit            tmo;
        bit            exp_err;
        int            acc;
        int            guard;

        exp_pw  = wr ? wd : model_pw;
        exp_st  = wr ? st : '0;
        // PREADY arrives on ACCESS cycle waits+1; beyond TO cycles the abort fires first
        tmo     = (waits + 1 > TO);
        acc     = tmo ? TO : waits + 1;
        exp_rd  = (tmo || wr) ? '0 : rd;
        exp_err = tmo ? 1'b1 : serr;

        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("cmd_ready_wait", {63'd0, bus.cmd_ready}, 64'd1);

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_strb  = st;
        bus.cmd_prot  = pr;
        tick();
        model_pw = exp_pw;

        // SETUP cycle: scramble inputs to show the command was latched and APB inputs ignored
        bus.cmd_valid = 1'b0;
        junk_cmd();
        junk_apb(1'($urandom));
        chk("setup_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b10);
        chk("setup_cmd_ready", bus.cmd_ready, 0);
        chk("setup_rsp_valid", bus.rsp_valid, 0);
        chk("setup_paddr", bus.PADDR, a);
        chk("setup_pwrite", bus.PWRITE, wr);
        chk("setup_pwdata", bus.PWDATA, exp_pw);
        chk("setup_pstrb", bus.PSTRB, exp_st);
        chk("setup_pprot", bus.PPROT, pr);
        tick();

        for (int k = 1; k <= acc; k++) begin
            chk("access_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b11);
            chk("access_rsp_valid", bus.rsp_valid, 0);
            chk("access_paddr", bus.PADDR, a);
            chk("access_pwdata", bus.PWDATA, exp_pw);
            chk("access_pstrb", bus.PSTRB, exp_st);
            chk("access_pprot", bus.PPROT, pr);
            if (!tmo && k == acc) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = serr;
                bus.PRDATA  = rd;
            end else begin
                junk_apb(1'b0);
            end
            tick();
        end

        junk_apb(1'($urandom));
        if (pend) begin
            bus.cmd_valid = 1'b1;
            junk_cmd();
        end
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", bus.rsp_valid, 1);
            chk("resp_rdata", bus.rsp_rdata, exp_rd);
            chk("resp_err", bus.rsp_err, exp_err);
            chk("resp_timeout", bus.rsp_timeout, tmo);
            chk("resp_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
            chk("resp_cmd_ready", bus.cmd_ready, 0);
            chk("resp_paddr_kept", bus.PADDR, a);
            if (h == hold) bus.rsp_ready = 1'b1;
            tick();
        end

        chk("done_rsp_valid", bus.rsp_valid, 0);
        chk("done_cmd_ready", bus.cmd_ready, 1);
        chk("done_no_accept", bus.PSEL, 0);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        junk_apb(1'b0);
    endtask

    task automatic reset_mid_access();
        int guard;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("rst_cmd_ready_wait", {63'd0, bus.cmd_ready}, 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0000_0080;
        bus.cmd_wdata = 32'h1357_9BDF;
        bus.cmd_strb  = 4'hF;
        bus.cmd_prot  = 3'd1;
        tick();
        bus.cmd_valid = 1'b0;
        junk_apb(1'b0);
        tick();
        chk("rst_pre_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_psel_penable", {bus.PSEL, bus.PENABLE}, 2'b00);
        chk("rst_async_paddr", bus.PADDR, 0);
        chk("rst_async_pwdata", bus.PWDATA, 0);
        chk("rst_async_cmd_ready", bus.cmd_ready, 0);
        chk("rst_async_rsp_valid", bus.rsp_valid, 0);
        model_pw = '0;
        junk_apb(1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        junk_apb(1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_after_rsp_valid", bus.rsp_valid, 0);
            chk("rst_after_cmd_ready", bus.cmd_ready, 1);
            tick();
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        junk_cmd();
        junk_apb(1'b0);

        tick();
        tick();
        chk("reset_psel", bus.PSEL, 0);
        chk("reset_penable", bus.PENABLE, 0);
        chk("reset_pwrite", bus.PWRITE, 0);
        chk("reset_paddr", bus.PADDR, 0);
        chk("reset_pwdata", bus.PWDATA, 0);
        chk("reset_pstrb", bus.PSTRB, 0);
        chk("reset_pprot", bus.PPROT, 0);
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_rdata", bus.rsp_rdata, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_rsp_timeout", bus.rsp_timeout, 0);
        rst_n = 1'b1;
        chk("release_cmd_ready_low", bus.cmd_ready, 0);
        tick();
        chk("release_cmd_ready_high", bus.cmd_ready, 1);

        // Plain write, zero wait
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 32'h0, 0, 1'b0);
        // Read with two wait states, strobes presented on the command are dropped
        xfer(1'b0, 32'h20, 32'h5555_AAAA, 4'hF, 3'd2, 2, 1'b0, 32'h1234_5678, 0, 1'b0);
        // Completer error on a read still returns PRDATA
        xfer(1'b0, 32'h24, 32'h0, 4'h3, 3'd5, 0, 1'b1, 32'hCAFE_F00D, 0, 1'b0);
        // PREADY on the last cycle before abort completes normally
        xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'd7, TO - 1, 1'b0, 32'hA5A5_A5A5, 0, 1'b0);
        // PREADY never arrives within the budget
        xfer(1'b1, 32'h34, 32'h0BAD_F00D, 4'h6, 3'd3, 50, 1'b0, 32'h0, 0, 1'b0);
        // Slow consumer with a command already waiting
        xfer(1'b1, 32'h40, 32'h8765_4321, 4'h9, 3'd4, 1, 1'b0, 32'h0, 5, 1'b1);

        reset_mid_access();
        xfer(1'b0, 32'h44, 32'h0, 4'hF, 3'd1, 0, 1'b0, 32'h0F0F_0F0F, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            xfer(1'($urandom), $urandom, $urandom, SW'($urandom), 3'($urandom),
                 $urandom_range(0, 6), 1'($urandom), $urandom,
                 $urandom_range(0, 3), 1'($urandom));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb4_master.md
APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values are 8, 16 and 32.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the number of PREADY-low ACCESS cycles before abort; a value of 0 disables the timeout.
REQ-004 SHALL have ports as follows; there is one clock, and reset is asynchronous and active-low.
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data
- rsp_err  out  1  PSLVERR or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PSTRB  out  DATA_WIDTH/8  APB4 strobes
- PPROT  out  3  APB4 protection
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  completer ready
- PSLVERR  in  1  completer error

Function
REQ-005 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP; every output SHALL be driven from registers.
REQ-006 SHALL hold cmd_ready=1 only in IDLE; a command is accepted on a PCLK edge where cmd_valid&&cmd_ready, and the FSM moves IDLE->SETUP.
REQ-007 On acceptance, SHALL latch the command fields into PADDR, PWRITE, PWDATA, PSTRB and PPROT.
- For reads, PSTRB SHALL be 0.
- For reads, PWDATA SHALL hold its previous value.
REQ-008 In SETUP, SHALL drive PSEL=1 and PENABLE=0 for exactly one cycle, then move to ACCESS.
REQ-009 In ACCESS, SHALL drive PSEL=1 and PENABLE=1; PADDR, PWRITE, PWDATA, PSTRB and PPROT SHALL remain stable from SETUP until completion.
REQ-010 In ACCESS, completion SHALL occur on an edge with PREADY=1, with the following registered outcome:
- PSEL=0 and PENABLE=0.
- rsp_rdata=PRDATA for a read, 0 for a write.
- rsp_err=PSLVERR and rsp_timeout=0.
- The FSM moves to RESP.
REQ-011 SHALL count consecutive ACCESS cycles with PREADY=0.
- When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES, the transfer SHALL abort: PSEL=0, PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, next state RESP.
- The counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1.
- The counter SHALL clear on entry to SETUP.
REQ-012 If PREADY=1 on the same edge the timeout count is reached, normal completion (REQ-010) SHALL take priority.
REQ-013 In RESP, SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready=1, then move to IDLE; rsp_valid SHALL drop on that edge.
REQ-014 Minimum latency SHALL be as follows:
- Accept at edge N, SETUP during cycle N+1, ACCESS during cycle N+2.
- With PREADY=1, rsp_valid=1 from cycle N+3.
- With rsp_ready tied high, the next command is accepted at edge N+4.
REQ-015 SHALL ignore PRDATA, PREADY and PSLVERR outside ACCESS.
REQ-016 In IDLE and RESP, SHALL hold PSEL=0 and PENABLE=0, and PADDR, PWRITE, PWDATA, PSTRB and PPROT SHALL retain their last values.
REQ-017 SHALL never assert PENABLE without PSEL, nor in two consecutive transfers without an intervening SETUP.

Reset
REQ-018 While PRESETn=0, SHALL asynchronously force the following:
- state=IDLE.
- PSEL, PENABLE, PWRITE = 0.
- PADDR, PWDATA, PSTRB, PPROT = 0.
- cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
- Timeout counter = 0.
REQ-019 After PRESETn rises, SHALL drive cmd_ready=1 from the first PCLK edge onward.
REQ-020 Reset asserted mid-transfer or mid-response SHALL discard the transfer and response with no rsp_valid generated.

Verification
REQ-021 Write: cmd addr 0x10, wdata 0xDEADBEEF, strb 0xF, PREADY=1 -> PSEL/PENABLE 1/0 then 1/1, PSTRB=0xF, rsp_valid 3 cycles after accept with rsp_err=0.
REQ-022 Read with 2 wait states: PRDATA=0x12345678 on the PREADY=1 cycle -> ACCESS lasts 3 cycles, rsp_rdata=0x12345678, PSTRB=0 throughout.
REQ-023 PSLVERR=1 with PREADY=1 on a read -> rsp_err=1, rsp_timeout=0, rsp_rdata=PRDATA.
REQ-024 TIMEOUT_CYCLES=4 with PREADY stuck low -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY=1 on the 4th cycle -> normal completion instead.
REQ-025 rsp_ready held low for 5 cycles -> rsp_valid and data remain stable, cmd_ready=0, and a pending cmd_valid is not accepted until one cycle after rsp_ready.
REQ-026 PRESETn pulsed low during ACCESS -> PSEL and PENABLE drop immediately, no rsp_valid, and a fresh command completes normally after release.
